spi_master_ctrl: RTL and testbench

Parametrised SPI master, the successor to the current fixed-mode SPI core. Adds runtime CPOL/CPHA mode selection, a programmable SCLK divider, MSB/LSB-first ordering and multiple active-low slave selects. It sits between the bus-side register strobe logic and the SPI pins: one transfer of DWIDTH bits is launched per accepted write, with done/busy status back to the bus.

---
 rtl/spi_master_ctrl.sv | 144 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master: one DWIDTH-bit transfer per accepted write, runtime CPOL/CPHA/bit order/divider/slave select.
// Latency accept->done = (2*DWIDTH+2)*(clk_div+1) clk; writes outside IDLE are dropped, never queued.
module spi_master_ctrl #(
  parameter int DWIDTH = 8,
  parameter int NSS    = 4,
  parameter int DIVW   = 8,
  localparam int SSW   = (NSS > 1) ? $clog2(NSS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr,
  input  logic [DWIDTH-1:0] din,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIVW-1:0]   clk_div,
  input  logic [SSW-1:0]    ss_sel,
  output logic [DWIDTH-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NSS-1:0]    ss_n
);

  localparam int ECW = $clog2(2 * DWIDTH);
  localparam logic [ECW-1:0] ELAST = ECW'(2 * DWIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t            state_q, state_d;
  logic [DIVW-1:0]   hcnt_q, div_q;
  logic [ECW-1:0]    ecnt_q;
  logic [DWIDTH-1:0] tx_q, rx_q;
  logic              cpol_q, cpha_q, lsb_q;
  logic [NSS-1:0]    ss_dec;

  logic accept, hp_end;
  logic first_edge, edge_x, leading, finish;
  logic do_toggle, do_sample, do_shift;

  assign accept = (state_q == IDLE) && cs && wr;
  assign hp_end = (hcnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (hp_end) state_d = XFER;
      XFER:    if (hp_end && ecnt_q == '0) state_d = HOLD;
      HOLD:    if (hp_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge strobes: the leading edge is the one leaving the idle level.
  always_comb begin
    first_edge = 1'b0;
    edge_x     = 1'b0;
    finish     = 1'b0;
    case (state_q)
      SETUP:   first_edge = hp_end;
      XFER:    edge_x     = hp_end && (ecnt_q != '0);
      HOLD:    finish     = hp_end;
      default: ;
    endcase
    leading   = (sclk == cpol_q);
    do_toggle = first_edge | edge_x;
    do_sample = do_toggle & (leading ^ cpha_q);
    do_shift  = edge_x & (cpha_q ? leading : (!leading && ecnt_q != ECW'(1)));
  end

  // Out-of-range selects match no line, so every ss_n stays high.
  always_comb begin
    ss_dec = '1;
    for (int i = 0; i < NSS; i++)
      if (ss_sel == SSW'(i)) ss_dec[i] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      div_q  <= '0;
      ecnt_q <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q  <= 1'b0;
      dout   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      ss_n   <= '1;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) sclk <= cpol;

      if (accept) begin
        tx_q   <= din;
        rx_q   <= '0;
        cpol_q <= cpol;
        cpha_q <= cpha;
        lsb_q  <= lsb_first;
        div_q  <= clk_div;
        hcnt_q <= clk_div;
        ecnt_q <= ELAST;
        mosi   <= lsb_first ? din[0] : din[DWIDTH-1];
        ss_n   <= ss_dec;
        busy   <= 1'b1;
      end else if (state_q != IDLE) begin
        hcnt_q <= hp_end ? div_q : hcnt_q - DIVW'(1);
      end

      if (state_q == XFER && hp_end) ecnt_q <= ecnt_q - ECW'(1);

      if (do_toggle) sclk <= ~sclk;

      if (do_sample)
        rx_q <= lsb_q ? {miso, rx_q[DWIDTH-1:1]} : {rx_q[DWIDTH-2:0], miso};

      if (do_shift) begin
        tx_q <= lsb_q ? (tx_q >> 1) : (tx_q << 1);
        mosi <= lsb_q ? tx_q[1] : tx_q[DWIDTH-2];
      end

      if (finish) begin
        ss_n <= '1;
        dout <= rx_q;
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: SPI slave model plus expected timing/data from transfer-level rules.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cs, wr, cpol, cpha, lsb_first, miso;
  logic [7:0] din, clk_div, dout;
  logic [1:0] ss_sel;
  logic       busy, done, sclk, mosi;
  logic [3:0] ss_n;

  logic       cs2, wr2, miso2;
  logic [2:0] ss_sel2;
  logic [7:0] dout2;
  logic       busy2, done2, sclk2, mosi2;
  logic [4:0] ss_n2;

  int n_cmp = 0;
  int n_err = 0;

  spi_master_ctrl #(.DWIDTH(8), .NSS(4), .DIVW(8)) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .din(din), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .clk_div(clk_div), .ss_sel(ss_sel), .dout(dout),
    .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  spi_master_ctrl #(.DWIDTH(8), .NSS(5), .DIVW(8)) dut2 (
    .clk(clk), .rst(rst), .cs(cs2), .wr(wr2), .din(din), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .clk_div(clk_div), .ss_sel(ss_sel2), .dout(dout2),
    .busy(busy2), .done(done2), .sclk(sclk2), .mosi(mosi2), .miso(miso2), .ss_n(ss_n2)
  );

  // SPI slave model reacting to the pins of the main instance.
  logic       m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0, m_loop = 1'b0;
  logic [7:0] m_word = '0;
  logic [7:0] mosi_seq = '0;
  logic       slv_miso = 1'b0;
  int         s_tx = 0, s_rx = 0;
  logic       sel_act;

  assign sel_act = ~&ss_n;
  assign miso    = m_loop ? mosi : slv_miso;

  always @(posedge sel_act) begin
    s_tx = 0;
    s_rx = 0;
    mosi_seq = '0;
    if (!m_cpha) begin
      slv_miso = m_lsb ? m_word[0] : m_word[7];
      s_tx = 1;
    end
  end

  always @(sclk) begin
    if (sel_act === 1'b1) begin
      if ((sclk !== m_cpol) ^ m_cpha) begin
        if (s_rx < 8) begin mosi_seq[s_rx] = mosi; s_rx++; end
      end else begin
        if (s_tx < 8) begin slv_miso = m_lsb ? m_word[s_tx] : m_word[7 - s_tx]; s_tx++; end
      end
    end
  end

  // Word the slave saw on MOSI, put back into din bit positions.
  function automatic logic [7:0] cap_word();
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[m_lsb ? i : 7 - i] = mosi_seq[i];
    return w;
  endfunction

  task automatic do_xfer(input logic [7:0] d, input logic pol, input logic pha, input logic lsb,
                         input logic [7:0] div, input logic [1:0] sel, input logic [7:0] sword,
                         input bit loop, input bit b2b, input int inject_k,
                         output int lat, output int nedge, output bit ss_ok, output bit busy_ok);
    logic [3:0] one, exp_ss;
    logic       prev;
    int         k;
    if (!b2b) begin
      @(negedge clk); cpol = pol;
      @(negedge clk);
    end
    m_cpol = pol; m_cpha = pha; m_lsb = lsb; m_word = sword; m_loop = loop;
    din = d; cpha = pha; lsb_first = lsb; clk_div = div; ss_sel = sel;
    cs = 1'b1; wr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    din = 8'($urandom); cpha = 1'($urandom); lsb_first = 1'($urandom);
    clk_div = 8'($urandom); ss_sel = 2'($urandom);
    one = 4'b0001;
    exp_ss = ~(one << sel);
    k = 0; lat = -1; nedge = 0; ss_ok = 1'b1; busy_ok = 1'b1;
    prev = sclk;
    while (k < 6000 && lat < 0) begin
      if (k > 0 && sclk !== prev) nedge++;
      prev = sclk;
      if (done === 1'b1) lat = k;
      else begin
        if (ss_n !== exp_ss) ss_ok = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (k == inject_k) begin din = 8'hFF; cs = 1'b1; wr = 1'b1; end
        else begin cs = 1'b0; wr = 1'b0; end
        @(negedge clk);
        k++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cs = 0; wr = 0; din = '0; cpol = 0; cpha = 0; lsb_first = 0;
    clk_div = '0; ss_sel = '0; cs2 = 0; wr2 = 0; ss_sel2 = '0; miso2 = 0;
    #3;
    n_cmp++; if (sclk !== 1'b0)   begin n_err++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    n_cmp++; if (mosi !== 1'b0)   begin n_err++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    n_cmp++; if (ss_n !== 4'hF)   begin n_err++; $display("FAIL reset_ss_n: got %b want 1111", ss_n); end
    n_cmp++; if (dout !== 8'h00)  begin n_err++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle_cpol;
    @(negedge clk); cpol = 1'b1;
    @(negedge clk);
    n_cmp++; if (sclk !== 1'b1) begin n_err++; $display("FAIL idle_cpol_hi: got %b want 1", sclk); end
    cpol = 1'b0;
    @(negedge clk);
    n_cmp++; if (sclk !== 1'b0) begin n_err++; $display("FAIL idle_cpol_lo: got %b want 0", sclk); end
  endtask

  task automatic test_mode0_loopback;
    int lat, ne; bit sok, bok;
    do_xfer(8'hA5, 0, 0, 0, 8'd1, 2'd2, 8'h00, 1, 0, -1, lat, ne, sok, bok);
    n_cmp++; if (!sok)        begin n_err++; $display("FAIL m0_ss_n: not held at 1011 during transfer"); end
    n_cmp++; if (ne !== 16)   begin n_err++; $display("FAIL m0_edges: got %0d want 16", ne); end
    n_cmp++; if (lat !== 36)  begin n_err++; $display("FAIL m0_latency: got %0d want 36", lat); end
    n_cmp++; if (dout !== 8'hA5) begin n_err++; $display("FAIL m0_dout: got %h want a5", dout); end
    n_cmp++; if (ss_n !== 4'hF) begin n_err++; $display("FAIL m0_ss_release: got %b want 1111", ss_n); end
    n_cmp++; if (mosi !== 1'b1) begin n_err++; $display("FAIL m0_mosi_hold: got %b want 1", mosi); end
    n_cmp++; if (!bok)        begin n_err++; $display("FAIL m0_busy: dropped during transfer"); end
  endtask

  task automatic test_mode3_lsb;
    int lat, ne; bit sok, bok;
    logic [7:0] exp_seq;
    @(negedge clk); cpol = 1'b1;
    @(negedge clk);
    n_cmp++; if (sclk !== 1'b1) begin n_err++; $display("FAIL m3_idle_sclk: got %b want 1", sclk); end
    do_xfer(8'h3C, 1, 1, 1, 8'd1, 2'd0, 8'hC1, 0, 0, -1, lat, ne, sok, bok);
    exp_seq = 8'b0011_1100;
    n_cmp++; if (mosi_seq !== exp_seq) begin n_err++; $display("FAIL m3_mosi_seq: got %b want %b (bit i = i-th bit sent)", mosi_seq, exp_seq); end
    n_cmp++; if (dout !== 8'hC1) begin n_err++; $display("FAIL m3_dout: got %h want c1", dout); end
    n_cmp++; if (sclk !== 1'b1)  begin n_err++; $display("FAIL m3_sclk_rest: got %b want 1", sclk); end
    n_cmp++; if (lat !== 36)     begin n_err++; $display("FAIL m3_latency: got %0d want 36", lat); end
  endtask

  task automatic test_mode1_2_div0;
    int lat, ne; bit sok, bok;
    for (int m = 1; m <= 2; m++) begin
      do_xfer(8'($urandom), (m == 2), (m == 1), 0, 8'd0, 2'd1, 8'h5A, 0, 0, -1, lat, ne, sok, bok);
      n_cmp++; if (dout !== 8'h5A) begin n_err++; $display("FAIL mode%0d_dout: got %h want 5a", m, dout); end
      n_cmp++; if (lat !== 18)     begin n_err++; $display("FAIL mode%0d_latency: got %0d want 18", m, lat); end
      n_cmp++; if (ne !== 16)      begin n_err++; $display("FAIL mode%0d_edges: got %0d want 16", m, ne); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, ne; bit sok, bok;
    do_xfer(8'h12, 0, 0, 0, 8'd1, 2'd1, 8'hE7, 0, 0, 10, lat, ne, sok, bok);
    n_cmp++; if (cap_word() !== 8'h12) begin n_err++; $display("FAIL b2b_ignored_wr_mosi: got %h want 12", cap_word()); end
    n_cmp++; if (dout !== 8'hE7) begin n_err++; $display("FAIL b2b_first_dout: got %h want e7", dout); end
    n_cmp++; if (lat !== 36)     begin n_err++; $display("FAIL b2b_first_latency: got %0d want 36", lat); end
    do_xfer(8'h9C, 0, 1, 0, 8'd1, 2'd3, 8'h3B, 0, 1, -1, lat, ne, sok, bok);
    n_cmp++; if (!bok)           begin n_err++; $display("FAIL b2b_second_start: busy not high from cycle after done"); end
    n_cmp++; if (!sok)           begin n_err++; $display("FAIL b2b_second_ss_n: select not held at 0111"); end
    n_cmp++; if (lat !== 36)     begin n_err++; $display("FAIL b2b_second_latency: got %0d want 36", lat); end
    n_cmp++; if (dout !== 8'h3B) begin n_err++; $display("FAIL b2b_second_dout: got %h want 3b", dout); end
    n_cmp++; if (cap_word() !== 8'h9C) begin n_err++; $display("FAIL b2b_second_mosi: got %h want 9c", cap_word()); end
  endtask

  task automatic test_random;
    int lat, ne, exp_lat; bit sok, bok;
    logic [7:0] d, w, div;
    logic [1:0] sel;
    logic       p, h, l;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom); w = 8'($urandom); p = 1'($urandom); h = 1'($urandom); l = 1'($urandom);
      sel = 2'($urandom);
      div = (i == 0) ? 8'hFF : 8'($urandom_range(0, 3));
      exp_lat = 18 * (int'(div) + 1);
      do_xfer(d, p, h, l, div, sel, w, 0, 0, -1, lat, ne, sok, bok);
      n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_lat); end
      n_cmp++; if (ne !== 16)       begin n_err++; $display("FAIL rnd%0d_edges: got %0d want 16", i, ne); end
      n_cmp++; if (!sok)            begin n_err++; $display("FAIL rnd%0d_ss_n: select %0d not held", i, sel); end
      n_cmp++; if (dout !== w)      begin n_err++; $display("FAIL rnd%0d_dout: got %h want %h", i, dout, w); end
      n_cmp++; if (cap_word() !== d) begin n_err++; $display("FAIL rnd%0d_mosi: got %h want %h", i, cap_word(), d); end
      n_cmp++; if (sclk !== p)      begin n_err++; $display("FAIL rnd%0d_sclk_rest: got %b want %b", i, sclk, p); end
    end
  endtask

  task automatic test_ss_out_of_range;
    int k, lat, ne, exp_lat;
    bit ss_ok;
    logic prev, mb;
    logic [7:0] div;
    div = 8'($urandom_range(0, 2));
    mb = 1'($urandom);
    exp_lat = 18 * (int'(div) + 1);
    @(negedge clk); cpol = 1'b0;
    @(negedge clk);
    din = 8'($urandom); cpha = 1'($urandom); lsb_first = 1'($urandom); clk_div = div;
    ss_sel2 = 3'd5; miso2 = mb; cs2 = 1'b1; wr2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cs2 = 1'b0; wr2 = 1'b0;
    k = 0; lat = -1; ne = 0; ss_ok = 1'b1; prev = sclk2;
    while (k < 2000 && lat < 0) begin
      if (k > 0 && sclk2 !== prev) ne++;
      prev = sclk2;
      if (ss_n2 !== 5'b11111) ss_ok = 1'b0;
      if (done2 === 1'b1) lat = k;
      else begin @(negedge clk); k++; end
    end
    n_cmp++; if (!ss_ok)        begin n_err++; $display("FAIL oor_ss_n: a select line asserted for ss_sel=5"); end
    n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL oor_latency: got %0d want %0d", lat, exp_lat); end
    n_cmp++; if (ne !== 16)     begin n_err++; $display("FAIL oor_edges: got %0d want 16", ne); end
    n_cmp++; if (dout2 !== {8{mb}}) begin n_err++; $display("FAIL oor_dout: got %h want %h", dout2, {8{mb}}); end
  endtask

  task automatic test_reset_mid;
    int ne, k;
    bit saw_done;
    logic prev;
    @(negedge clk); cpol = 1'b0;
    @(negedge clk);
    m_cpol = 0; m_cpha = 0; m_lsb = 0; m_loop = 1; m_word = '0;
    din = 8'($urandom); cpha = 0; lsb_first = 0; clk_div = 8'd2; ss_sel = 2'd1;
    cs = 1'b1; wr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    ne = 0; k = 0; prev = sclk;
    while (ne < 5 && k < 500) begin
      @(negedge clk); k++;
      if (sclk !== prev) ne++;
      prev = sclk;
    end
    n_cmp++; if (ne !== 5) begin n_err++; $display("FAIL rmid_reach_edge5: got %0d edges want 5", ne); end
    rst = 1'b1;
    #1;
    n_cmp++; if (ss_n !== 4'hF)  begin n_err++; $display("FAIL rmid_ss_n: got %b want 1111", ss_n); end
    n_cmp++; if (sclk !== 1'b0)  begin n_err++; $display("FAIL rmid_sclk: got %b want 0", sclk); end
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL rmid_dout: got %h want 00", dout); end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done)       begin n_err++; $display("FAIL rmid_no_done: got done pulse want none"); end
    n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL rmid_dout_after: got %h want 00", dout); end
  endtask

  initial begin
    test_reset();
    test_idle_cpol();
    test_mode0_loopback();
    test_mode3_lsb();
    test_mode1_2_div0();
    test_back_to_back();
    test_random();
    test_ss_out_of_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
